// File: rtl/ece429_mem_arbiter.sv
// Main-memory arbiter and boot sequencer. Shares one synchronous memory
// between the SREC loader, instruction fetch and the data-memory stage,
// issues 1/4/8/16-word bursts and keeps the CPU stalled until boot completes.
// Vectors are written [31:0]; the two ignored low address bits are [1:0].
module ece429_mem_arbiter #(
    parameter int BOOT_REQUIRED = 1,
    parameter int STARVE_LIMIT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_req,
    input  logic        if_req,
    input  logic        dm_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] if_addr,
    input  logic [31:0] dm_addr,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  if_size,
    input  logic [1:0]  dm_size,
    input  logic        dm_rw,
    input  logic [31:0] ld_wdata,
    input  logic [31:0] dm_wdata,
    input  logic        ld_done,
    output logic        ld_ack,
    output logic        if_ack,
    output logic        dm_ack,
    output logic        if_rvalid,
    output logic        dm_rvalid,
    output logic [31:0] rdata,
    output logic        ld_bdone,
    output logic        if_bdone,
    output logic        dm_bdone,
    output logic        boot_done,
    output logic        cpu_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_BURST   = 1'b1;
    localparam logic [1:0]  OWN_NONE   = 2'd0;
    localparam logic [1:0]  OWN_LD     = 2'd1;
    localparam logic [1:0]  OWN_IF     = 2'd2;
    localparam logic [1:0]  OWN_DM     = 2'd3;
    localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC;
    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic        BOOT_INIT  = (BOOT_REQUIRED == 0);

    logic [0:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  beats_q, beats_d;
    logic        rw_q, rw_d;
    logic [7:0]  starve_q, starve_d;
    logic        boot_done_q, boot_done_d;
    logic        ld_pend_q, ld_pend_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        dm_rvalid_q, dm_rvalid_d;

    logic        issue, last_beat, cur_rw, owner_req, grant_if, grant_dm;
    logic [1:0]  cur_owner;
    logic [31:0] cur_addr;
    logic [4:0]  grant_beats;
    logic        if_elig, dm_elig, if_forced, ld_busy, ld_end;

    function automatic logic [4:0] size_to_beats(input logic [1:0] size);
        case (size)
            2'b00:   return 5'd1;
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    assign if_elig   = if_req && boot_done_q;
    assign dm_elig   = dm_req && boot_done_q;
    assign if_forced = if_elig && (starve_q >= STARVE_MAX);

    // Arbitration in IDLE and beat sequencing in BURST; the first beat of a grant issues combinationally.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        rw_d        = rw_q;
        issue       = 1'b0;
        last_beat   = 1'b0;
        cur_owner   = OWN_NONE;
        cur_addr    = '0;
        cur_rw      = 1'b0;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        grant_beats = 5'd0;
        case (owner_q)
            OWN_LD:  owner_req = ld_req;
            OWN_IF:  owner_req = if_req;
            OWN_DM:  owner_req = dm_req;
            default: owner_req = 1'b0;
        endcase
        // Reset is folded in so outputs drop the instant it rises, not at the next edge.
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                if (ld_req) begin
                    cur_owner   = OWN_LD;
                    cur_addr    = ld_addr & ADDR_MASK;
                    cur_rw      = 1'b1;
                    grant_beats = size_to_beats(ld_size);
                end else if (if_forced || (if_elig && !dm_elig)) begin
                    cur_owner   = OWN_IF;
                    cur_addr    = if_addr & ADDR_MASK;
                    grant_beats = size_to_beats(if_size);
                    grant_if    = 1'b1;
                end else if (dm_elig) begin
                    cur_owner   = OWN_DM;
                    cur_addr    = dm_addr & ADDR_MASK;
                    cur_rw      = dm_rw;
                    grant_beats = size_to_beats(dm_size);
                    grant_dm    = 1'b1;
                end
                issue     = (cur_owner != OWN_NONE);
                last_beat = issue && (grant_beats == 5'd1);
                if (issue && !last_beat) begin
                    state_d = ST_BURST;
                    owner_d = cur_owner;
                    addr_d  = cur_addr + 32'd4;
                    beats_d = grant_beats - 5'd1;
                    rw_d    = cur_rw;
                end
            end else if (owner_req) begin
                issue     = 1'b1;
                cur_owner = owner_q;
                cur_addr  = addr_q;
                cur_rw    = rw_q;
                last_beat = (beats_q == 5'd1);
                addr_d    = addr_q + 32'd4;
                beats_d   = beats_q - 5'd1;
                if (last_beat) state_d = ST_IDLE;
            end else begin
                // Owner withdrew mid-burst: abandon it without issuing a beat.
                state_d = ST_IDLE;
            end
        end
    end

    // Starvation counter, boot tracking and read-return flags.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if)                    starve_d = 8'd0;
        else if (grant_dm && starve_q != 8'hFF)     starve_d = starve_q + 8'd1;

        ld_busy     = (state_q == ST_BURST) && (owner_q == OWN_LD);
        ld_end      = ld_busy && (state_d == ST_IDLE);
        ld_pend_d   = ld_pend_q || (ld_done && ld_busy);
        boot_done_d = boot_done_q || ((ld_done || ld_pend_q) && (!ld_busy || ld_end));

        if_rvalid_d = issue && !cur_rw && (cur_owner == OWN_IF);
        dm_rvalid_d = issue && !cur_rw && (cur_owner == OWN_DM);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            beats_q     <= '0;
            rw_q        <= 1'b0;
            starve_q    <= '0;
            boot_done_q <= BOOT_INIT;
            ld_pend_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            rw_q        <= rw_d;
            starve_q    <= starve_d;
            boot_done_q <= boot_done_d;
            ld_pend_q   <= ld_pend_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
        end
    end

    assign ld_ack    = issue && (cur_owner == OWN_LD);
    assign if_ack    = issue && (cur_owner == OWN_IF);
    assign dm_ack    = issue && (cur_owner == OWN_DM);
    assign ld_bdone  = ld_ack && last_beat;
    assign if_bdone  = if_ack && last_beat;
    assign dm_bdone  = dm_ack && last_beat;
    assign mem_en    = issue;
    assign mem_we    = issue && cur_rw;
    assign mem_addr  = cur_addr;
    assign mem_wdata = mem_we ? ((cur_owner == OWN_LD) ? ld_wdata : dm_wdata) : '0;
    // The memory's own output register supplies the data; pass it only while a read returns.
    assign rdata     = (if_rvalid_q || dm_rvalid_q) ? mem_rdata : '0;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign boot_done = boot_done_q;
    assign cpu_stall = ~boot_done_q;

endmodule
